// File: rtl/spike_axi_master.sv
// spike_axi_master: single-beat AXI master carrying Spike IO requests onto the CPUNC bus.
// Optional watchdog is compiled in when SPIKE_AXI_TIMEOUT_EN is defined.
module spike_axi_master #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [7:0]  AXI_ID_VAL     = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        CPUNC_ACLK,
    input  logic                        CPUNC_ARESETn,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]                  req_size,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,

    output logic [7:0]                  CPUNC_AWID,
    output logic [AXI_ADDR_WIDTH-1:0]   CPUNC_AWADDR,
    output logic [7:0]                  CPUNC_AWLEN,
    output logic [2:0]                  CPUNC_AWSIZE,
    output logic [1:0]                  CPUNC_AWBURST,
    output logic                        CPUNC_AWLOCK,
    output logic [3:0]                  CPUNC_AWCACHE,
    output logic [2:0]                  CPUNC_AWPROT,
    output logic [3:0]                  CPUNC_AWQOS,
    output logic                        CPUNC_AWVALID,
    input  logic                        CPUNC_AWREADY,

    output logic [7:0]                  CPUNC_WID,
    output logic [AXI_DATA_WIDTH-1:0]   CPUNC_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] CPUNC_WSTRB,
    output logic                        CPUNC_WLAST,
    output logic                        CPUNC_WVALID,
    input  logic                        CPUNC_WREADY,

    input  logic [1:0]                  CPUNC_BRESP,
    input  logic                        CPUNC_BVALID,
    output logic                        CPUNC_BREADY,

    output logic [7:0]                  CPUNC_ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   CPUNC_ARADDR,
    output logic [7:0]                  CPUNC_ARLEN,
    output logic [2:0]                  CPUNC_ARSIZE,
    output logic [1:0]                  CPUNC_ARBURST,
    output logic                        CPUNC_ARLOCK,
    output logic [3:0]                  CPUNC_ARCACHE,
    output logic [2:0]                  CPUNC_ARPROT,
    output logic [3:0]                  CPUNC_ARQOS,
    output logic                        CPUNC_ARVALID,
    input  logic                        CPUNC_ARREADY,

    input  logic [AXI_DATA_WIDTH-1:0]   CPUNC_RDATA,
    input  logic [1:0]                  CPUNC_RRESP,
    input  logic                        CPUNC_RLAST,
    input  logic                        CPUNC_RVALID,
    output logic                        CPUNC_RREADY
);

    localparam int unsigned DW = AXI_DATA_WIDTH;
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = $clog2(SW);

    if (DW != 32 && DW != 64) begin : g_bad_dw
        $error("spike_axi_master: AXI_DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("spike_axi_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

    state_t          state, next_state;
    logic            live;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic [DW-1:0]   wdata_q;
    logic [OW-1:0]   off_q;
    logic            aw_done, w_done;
    logic            accept, misaligned, tmo;
    logic            aw_hs, w_hs, both_done;
    logic [OW-1:0]   off_in, align_mask;
    logic [DW-1:0]   rd_lane;
    logic            unused_rlast;

    function automatic logic [DW-1:0] size_mask(input logic [1:0] sz);
        logic [DW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DW; i++) m[i] = (i < (32'd8 << sz));
        return m;
    endfunction

    function automatic logic [SW-1:0] lane_strb(input logic [OW-1:0] off, input logic [1:0] sz);
        logic [SW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < SW; i++)
            s[i] = (i >= 32'(off)) && (i < 32'(off) + (32'd1 << sz));
        return s;
    endfunction

    assign unused_rlast = CPUNC_RLAST;

    assign off_in     = req_addr[OW-1:0];
    assign align_mask = OW'((4'd1 << req_size) - 4'd1);
    assign misaligned = ((off_in & align_mask) != '0) || (req_size == 2'd3 && DW == 32);
    assign accept     = req_valid && req_ready;
    assign aw_hs      = CPUNC_AWVALID && CPUNC_AWREADY;
    assign w_hs       = CPUNC_WVALID && CPUNC_WREADY;
    assign both_done  = (aw_done || aw_hs) && (w_done || w_hs);
    assign rd_lane    = (CPUNC_RDATA >> {off_q, 3'b000}) & size_mask(size_q);

`ifdef SPIKE_AXI_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt;
    logic          active;

    assign active = (state == RADDR) || (state == RDATA) || (state == WRITE) || (state == WRESP);
    assign tmo    = active && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, so each bus phase gets its own budget.
    always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESETn) begin
        if (CPUNC_ARESETn)              tmo_cnt <= '0;
        else if (next_state != state)   tmo_cnt <= '0;
        else if (active)                tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESETn) begin
        if (CPUNC_ARESETn) state <= IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = misaligned ? RESP : (req_we ? WRITE : RADDR);
            RADDR: if (CPUNC_ARREADY) next_state = RDATA;
            RDATA: if (CPUNC_RVALID) next_state = RESP;
            WRITE: if (both_done) next_state = WRESP;
            WRESP: if (CPUNC_BVALID) next_state = RESP;
            RESP:  if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (tmo) next_state = RESP;
    end

    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        CPUNC_ARVALID = 1'b0;
        CPUNC_RREADY  = 1'b0;
        CPUNC_AWVALID = 1'b0;
        CPUNC_WVALID  = 1'b0;
        CPUNC_BREADY  = 1'b0;
        case (state)
            IDLE:  req_ready     = live;
            RADDR: CPUNC_ARVALID = 1'b1;
            RDATA: CPUNC_RREADY  = 1'b1;
            WRITE: begin
                CPUNC_AWVALID = !aw_done;
                CPUNC_WVALID  = !w_done;
            end
            WRESP: CPUNC_BREADY  = 1'b1;
            RESP:  rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    // live keeps req_ready low while reset is asserted even though state reads IDLE.
    always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESETn) begin
        if (CPUNC_ARESETn) begin
            live      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            off_q     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (tmo) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        wdata_q   <= req_wdata;
                        off_q     <= off_in;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= misaligned;
                    end
                    RDATA: if (CPUNC_RVALID) begin
                        rsp_rdata <= (CPUNC_RRESP != 2'b00) ? '0 : rd_lane;
                        rsp_err   <= (CPUNC_RRESP != 2'b00);
                    end
                    WRITE: begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                    WRESP: if (CPUNC_BVALID) begin
                        rsp_rdata <= '0;
                        rsp_err   <= (CPUNC_BRESP != 2'b00);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign CPUNC_AWID    = AXI_ID_VAL;
    assign CPUNC_AWADDR  = addr_q;
    assign CPUNC_AWLEN   = '0;
    assign CPUNC_AWSIZE  = {1'b0, size_q};
    assign CPUNC_AWBURST = 2'b01;
    assign CPUNC_AWLOCK  = 1'b0;
    assign CPUNC_AWCACHE = '0;
    assign CPUNC_AWPROT  = '0;
    assign CPUNC_AWQOS   = '0;

    assign CPUNC_WID     = AXI_ID_VAL;
    assign CPUNC_WDATA   = wdata_q << {off_q, 3'b000};
    assign CPUNC_WSTRB   = lane_strb(off_q, size_q);
    assign CPUNC_WLAST   = we_q;

    assign CPUNC_ARID    = AXI_ID_VAL;
    assign CPUNC_ARADDR  = addr_q;
    assign CPUNC_ARLEN   = '0;
    assign CPUNC_ARSIZE  = {1'b0, size_q};
    assign CPUNC_ARBURST = 2'b01;
    assign CPUNC_ARLOCK  = 1'b0;
    assign CPUNC_ARCACHE = '0;
    assign CPUNC_ARPROT  = '0;
    assign CPUNC_ARQOS   = '0;

endmodule

// File: tb/tb_spike_axi_master.sv
// Bench for spike_axi_master: 32-bit and 64-bit instances driven from one directed vector table.
module tb_spike_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [63:0] req_wdata = '0, rdata = '0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;

    always #5 clk = ~clk;

    // 32-bit instance outputs
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_awvalid, a_wvalid, a_wlast, a_bready;
    logic        a_arvalid, a_rready, a_awlock, a_arlock;
    logic [31:0] a_rsp_rdata, a_awaddr, a_araddr, a_wdata;
    logic [3:0]  a_wstrb, a_awcache, a_arcache, a_awqos, a_arqos;
    logic [2:0]  a_awsize, a_arsize, a_awprot, a_arprot;
    logic [1:0]  a_awburst, a_arburst;
    logic [7:0]  a_awid, a_awlen, a_wid, a_arid, a_arlen;
    // 64-bit instance outputs
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_awvalid, b_wvalid, b_wlast, b_bready;
    logic        b_arvalid, b_rready, b_awlock, b_arlock;
    logic [63:0] b_rsp_rdata, b_wdata;
    logic [31:0] b_awaddr, b_araddr;
    logic [7:0]  b_wstrb;
    logic [3:0]  b_awcache, b_arcache, b_awqos, b_arqos;
    logic [2:0]  b_awsize, b_arsize, b_awprot, b_arprot;
    logic [1:0]  b_awburst, b_arburst;
    logic [7:0]  b_awid, b_awlen, b_wid, b_arid, b_arlen;

    spike_axi_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_ID_VAL(8'h00), .TIMEOUT_CYCLES(16)) dut32 (
        .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst),
        .req_valid(req_valid && !sel64), .req_ready(a_req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel64), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .CPUNC_AWID(a_awid), .CPUNC_AWADDR(a_awaddr), .CPUNC_AWLEN(a_awlen), .CPUNC_AWSIZE(a_awsize),
        .CPUNC_AWBURST(a_awburst), .CPUNC_AWLOCK(a_awlock), .CPUNC_AWCACHE(a_awcache), .CPUNC_AWPROT(a_awprot),
        .CPUNC_AWQOS(a_awqos), .CPUNC_AWVALID(a_awvalid), .CPUNC_AWREADY(awready && !sel64),
        .CPUNC_WID(a_wid), .CPUNC_WDATA(a_wdata), .CPUNC_WSTRB(a_wstrb), .CPUNC_WLAST(a_wlast),
        .CPUNC_WVALID(a_wvalid), .CPUNC_WREADY(wready && !sel64),
        .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid && !sel64), .CPUNC_BREADY(a_bready),
        .CPUNC_ARID(a_arid), .CPUNC_ARADDR(a_araddr), .CPUNC_ARLEN(a_arlen), .CPUNC_ARSIZE(a_arsize),
        .CPUNC_ARBURST(a_arburst), .CPUNC_ARLOCK(a_arlock), .CPUNC_ARCACHE(a_arcache), .CPUNC_ARPROT(a_arprot),
        .CPUNC_ARQOS(a_arqos), .CPUNC_ARVALID(a_arvalid), .CPUNC_ARREADY(arready && !sel64),
        .CPUNC_RDATA(rdata[31:0]), .CPUNC_RRESP(rresp), .CPUNC_RLAST(1'b1), .CPUNC_RVALID(rvalid && !sel64),
        .CPUNC_RREADY(a_rready)
    );

    spike_axi_master #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_VAL(8'h00), .TIMEOUT_CYCLES(16)) dut64 (
        .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst),
        .req_valid(req_valid && sel64), .req_ready(b_req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel64), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .CPUNC_AWID(b_awid), .CPUNC_AWADDR(b_awaddr), .CPUNC_AWLEN(b_awlen), .CPUNC_AWSIZE(b_awsize),
        .CPUNC_AWBURST(b_awburst), .CPUNC_AWLOCK(b_awlock), .CPUNC_AWCACHE(b_awcache), .CPUNC_AWPROT(b_awprot),
        .CPUNC_AWQOS(b_awqos), .CPUNC_AWVALID(b_awvalid), .CPUNC_AWREADY(awready && sel64),
        .CPUNC_WID(b_wid), .CPUNC_WDATA(b_wdata), .CPUNC_WSTRB(b_wstrb), .CPUNC_WLAST(b_wlast),
        .CPUNC_WVALID(b_wvalid), .CPUNC_WREADY(wready && sel64),
        .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid && sel64), .CPUNC_BREADY(b_bready),
        .CPUNC_ARID(b_arid), .CPUNC_ARADDR(b_araddr), .CPUNC_ARLEN(b_arlen), .CPUNC_ARSIZE(b_arsize),
        .CPUNC_ARBURST(b_arburst), .CPUNC_ARLOCK(b_arlock), .CPUNC_ARCACHE(b_arcache), .CPUNC_ARPROT(b_arprot),
        .CPUNC_ARQOS(b_arqos), .CPUNC_ARVALID(b_arvalid), .CPUNC_ARREADY(arready && sel64),
        .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RLAST(1'b1), .CPUNC_RVALID(rvalid && sel64),
        .CPUNC_RREADY(b_rready)
    );

    // Observation view of whichever instance is selected
    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [63:0] m_rsp_rdata, m_wdata;
    logic [31:0] m_araddr, m_awaddr;
    logic [2:0]  m_arsize, m_awsize;
    logic [7:0]  m_wstrb;

    always_comb begin
        if (sel64) begin
            {m_req_ready, m_rsp_valid, m_rsp_err} = {b_req_ready, b_rsp_valid, b_rsp_err};
            {m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready} =
                {b_arvalid, b_rready, b_awvalid, b_wvalid, b_wlast, b_bready};
            m_rsp_rdata = b_rsp_rdata;  m_wdata  = b_wdata;   m_wstrb  = b_wstrb;
            m_araddr    = b_araddr;     m_awaddr = b_awaddr;  m_arsize = b_arsize; m_awsize = b_awsize;
        end else begin
            {m_req_ready, m_rsp_valid, m_rsp_err} = {a_req_ready, a_rsp_valid, a_rsp_err};
            {m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready} =
                {a_arvalid, a_rready, a_awvalid, a_wvalid, a_wlast, a_bready};
            m_rsp_rdata = {32'h0, a_rsp_rdata};  m_wdata  = {32'h0, a_wdata};  m_wstrb = {4'h0, a_wstrb};
            m_araddr    = a_araddr;  m_awaddr = a_awaddr;  m_arsize = a_arsize;  m_awsize = a_awsize;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        is64;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          aw_delay;
        int          rsp_delay;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_axi;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        int          exp_lat;
    } vec_t;

    task automatic wait_req_ready(input string name);
        int g;
        g = 0;
        while (!m_req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({name, ".req_ready"}, {63'h0, m_req_ready}, 64'h1);
    endtask

    task automatic run_txn(input vec_t v);
        int lat, ar_n, aw_n, w_n, b_n, rsp_n;
        logic [63:0] got_rdata, got_wdata;
        logic [31:0] got_araddr, got_awaddr;
        logic [2:0]  got_arsize, got_awsize;
        logic [7:0]  got_wstrb;
        logic        got_err, got_wlast, done;
        lat = 0; ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; rsp_n = 0; done = 1'b0;
        got_rdata = '0; got_wdata = '0; got_araddr = '0; got_awaddr = '0;
        got_arsize = '0; got_awsize = '0; got_wstrb = '0; got_err = 1'b0; got_wlast = 1'b0;
        sel64 = v.is64;
        @(negedge clk);
        wait_req_ready(v.name);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;
            if (m_arvalid) begin
                ar_n++; got_araddr = m_araddr; got_arsize = m_arsize; arready = 1'b1;
            end
            if (m_rready) begin
                rvalid = 1'b1; rdata = v.rdata; rresp = v.resp;
            end
            if (m_awvalid) begin
                aw_n++; got_awaddr = m_awaddr; got_awsize = m_awsize;
                awready = (aw_n >= v.aw_delay);
            end
            if (m_wvalid) begin
                w_n++; got_wdata = m_wdata; got_wstrb = m_wstrb; got_wlast = m_wlast; wready = 1'b1;
            end
            if (m_bready) begin
                b_n++; bvalid = 1'b1; bresp = v.resp;
            end
            if (m_rsp_valid) begin
                if (rsp_n == 0) lat = cyc;
                rsp_n++;
                if (rsp_n > v.rsp_delay) begin
                    rsp_ready = 1'b1; got_rdata = m_rsp_rdata; got_err = m_rsp_err; done = 1'b1;
                end
            end
            @(negedge clk);
        end
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;
        chk({v.name, ".rsp_seen"}, {63'h0, done}, 64'h1);
        chk({v.name, ".rsp_rdata"}, got_rdata, v.exp_rdata);
        chk({v.name, ".rsp_err"}, {63'h0, got_err}, {63'h0, v.exp_err});
        chk({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, ".rsp_cycles"}, 64'(rsp_n), 64'(v.rsp_delay + 1));
        chk({v.name, ".ready_after"}, {62'h0, m_req_ready, m_rsp_valid}, 64'h2);
        if (!v.exp_axi) begin
            chk({v.name, ".no_axi"}, 64'(ar_n + aw_n + w_n + b_n), 64'h0);
        end else if (v.we) begin
            chk({v.name, ".aw_cycles"}, 64'(aw_n), 64'((v.aw_delay > 1) ? v.aw_delay : 1));
            chk({v.name, ".w_cycles"}, 64'(w_n), 64'h1);
            chk({v.name, ".b_count"}, 64'(b_n), 64'h1);
            chk({v.name, ".ar_count"}, 64'(ar_n), 64'h0);
            chk({v.name, ".awaddr"}, {32'h0, got_awaddr}, {32'h0, v.addr});
            chk({v.name, ".awsize"}, {61'h0, got_awsize}, {62'h0, v.size});
            chk({v.name, ".wdata"}, got_wdata, v.exp_wdata);
            chk({v.name, ".wstrb"}, {56'h0, got_wstrb}, {56'h0, v.exp_wstrb});
            chk({v.name, ".wlast"}, {63'h0, got_wlast}, 64'h1);
        end else begin
            chk({v.name, ".ar_count"}, 64'(ar_n), 64'h1);
            chk({v.name, ".aw_count"}, 64'(aw_n + w_n), 64'h0);
            chk({v.name, ".araddr"}, {32'h0, got_araddr}, {32'h0, v.addr});
            chk({v.name, ".arsize"}, {61'h0, got_arsize}, {62'h0, v.size});
        end
    endtask

    function automatic vec_t mv(input string n, input logic s64, input logic we, input logic [31:0] a,
                                input logic [1:0] sz, input logic [63:0] wd, input logic [63:0] rd,
                                input logic [1:0] rs, input int awd, input int rspd, input logic [63:0] erd,
                                input logic eerr, input logic eaxi, input logic [63:0] ewd,
                                input logic [7:0] estb, input int elat);
        vec_t v;
        v.name = n; v.is64 = s64; v.we = we; v.addr = a; v.size = sz; v.wdata = wd; v.rdata = rd;
        v.resp = rs; v.aw_delay = awd; v.rsp_delay = rspd; v.exp_rdata = erd; v.exp_err = eerr;
        v.exp_axi = eaxi; v.exp_wdata = ewd; v.exp_wstrb = estb; v.exp_lat = elat;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        vecs[0]  = mv("rd32_word",     0, 0, 32'h10, 2, 64'h0, 64'hDEADBEEF, 0, 0, 0, 64'hDEADBEEF, 0, 1, 64'h0, 8'h00, 3);
        vecs[1]  = mv("wr32_byte3",    0, 1, 32'h13, 0, 64'hA5, 64'h0, 0, 0, 0, 64'h0, 0, 1, 64'hA500_0000, 8'h08, 3);
        vecs[2]  = mv("rd64_half6",    1, 0, 32'h06, 1, 64'h0, 64'h1234_0000_0000_0000, 0, 0, 0, 64'h1234, 0, 1, 64'h0, 8'h00, 3);
        vecs[3]  = mv("rd32_misalign", 0, 0, 32'h02, 2, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0, 64'h0, 8'h00, 1);
        vecs[4]  = mv("rd32_slverr",   0, 0, 32'h14, 2, 64'h0, 64'h55, 2, 0, 0, 64'h0, 1, 1, 64'h0, 8'h00, 3);
        vecs[5]  = mv("wr32_half_err", 0, 1, 32'h22, 1, 64'hBEEF, 64'h0, 3, 0, 2, 64'h0, 1, 1, 64'hBEEF_0000, 8'h0C, 3);
        vecs[6]  = mv("rd32_byte1",    0, 0, 32'h31, 0, 64'h0, 64'h1122_3344, 0, 0, 0, 64'h33, 0, 1, 64'h0, 8'h00, 3);
        vecs[7]  = mv("wr64_dword",    1, 1, 32'h40, 3, 64'h0102_0304_0506_0708, 64'h0, 0, 0, 0, 64'h0, 0, 1,
                      64'h0102_0304_0506_0708, 8'hFF, 3);
        vecs[8]  = mv("rd32_size3",    0, 0, 32'h40, 3, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0, 64'h0, 8'h00, 1);
        vecs[9]  = mv("wr64_word_hi",  1, 1, 32'h0C, 2, 64'hCAFE_F00D, 64'h0, 0, 0, 0, 64'h0, 0, 1,
                      64'hCAFE_F00D_0000_0000, 8'hF0, 3);
        vecs[10] = mv("wr32_aw_late",  0, 1, 32'h13, 0, 64'hA5, 64'h0, 0, 3, 0, 64'h0, 0, 1, 64'hA500_0000, 8'h08, 5);
        vecs[11] = mv("rd64_misalign", 1, 0, 32'h02, 2, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0, 64'h0, 8'h00, 1);
        vecs[12] = mv("rd64_dword",    1, 0, 32'h08, 3, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 0,
                      64'hFEDC_BA98_7654_3210, 0, 1, 64'h0, 8'h00, 3);
        vecs[13] = mv("rd32_rspwait",  0, 0, 32'h20, 2, 64'h0, 64'h0BAD_F00D, 0, 0, 3, 64'h0BAD_F00D, 0, 1, 64'h0, 8'h00, 3);

        // Reset state of both instances
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            chk($sformatf("reset%0d.handshakes", s),
                {57'h0, m_req_ready, m_rsp_valid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 64'h0);
            chk($sformatf("reset%0d.rsp", s), {m_rsp_rdata[62:0], m_rsp_err}, 64'h0);
        end
        chk("tie_ids32", {24'h0, a_awid, a_arid, a_wid, a_awlen, a_arlen}, 64'h0);
        chk("tie_misc32", {36'h0, a_awburst, a_arburst, a_awlock, a_arlock, a_awcache, a_arcache,
                           a_awprot, a_arprot, a_awqos, a_arqos}, 64'h0500_0000);
        chk("tie_misc64", {36'h0, b_awburst, b_arburst, b_awlock, b_arlock, b_awcache, b_arcache,
                           b_awprot, b_arprot, b_awqos, b_arqos}, 64'h0500_0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_txn(vecs[i]);

        // Reset while a write response is outstanding
        sel64 = 1'b0;
        @(negedge clk);
        wait_req_ready("rst_wresp");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_size = 2'd2; req_wdata = 64'h1111_2222;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10 && !m_bready; c++) begin
            awready = m_awvalid; wready = m_wvalid;
            @(negedge clk);
        end
        awready = 1'b0; wready = 1'b0;
        chk("rst_wresp.bready_before", {63'h0, m_bready}, 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wresp.outputs", {61'h0, m_bready, m_rsp_valid, m_req_ready}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(vecs[0]);

`ifdef SPIKE_AXI_TIMEOUT_EN
        begin
            int n;
            n = 0;
            sel64 = 1'b0;
            @(negedge clk);
            wait_req_ready("timeout");
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'd2;
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 40 && !m_rsp_valid; c++) begin
                if (m_arvalid) n++;
                @(negedge clk);
            end
            chk("timeout.ar_cycles", 64'(n), 64'd16);
            chk("timeout.rsp", {61'h0, m_rsp_valid, m_rsp_err, m_arvalid}, 64'h6);
            chk("timeout.rdata", m_rsp_rdata, 64'h0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            run_txn(vecs[1]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
